// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction-memory loader.
`default_nettype none

package riscv_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } loader_state_t;

  localparam int WORD_BYTES = 4;
  localparam int LEN_BYTES  = 2;

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
`default_nettype none

interface imem_loader_if;

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  // Stream source and memory sink side.
  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side.
  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/imem_loader_byte_assembler.sv
// Shifts accepted little-endian bytes into a 32-bit word; flags the last byte of each word.
`default_nettype none

module imem_loader_byte_assembler
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_last
);

  localparam int CW = $clog2(WORD_BYTES);

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_word;

  // Includes the byte being accepted, so the full word is ready on the last-byte cycle.
  assign o_word = {i_byte, r_word[31:8]};
  assign o_last = i_accept && (r_cnt == CW'(WORD_BYTES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
    end else if (i_accept) begin
      r_word <= o_word;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds the core in reset until done.
`default_nettype none

module imem_loader
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  start,
  imem_loader_if.slave bus,
  output logic  core_reset,
  output logic  busy,
  output logic  done,
  output logic  error
);

  localparam int IW = $clog2(DEPTH + 1);

  loader_state_t r_state;
  loader_state_t w_next;

  logic [15:0]   r_count;
  logic [IW-1:0] r_idx;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;

  logic          w_accept;
  logic          w_start;
  logic          w_last;
  logic          w_last_word;
  logic [15:0]   w_len;
  logic [31:0]   w_word;

  assign bus.byte_ready = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_DATA);
  assign bus.mem_we     = (r_state == S_WRITE);
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;

  assign busy       = bus.byte_ready || (r_state == S_WRITE);
  assign done       = (r_state == S_DONE);
  assign error      = (r_state == S_ERROR);
  assign core_reset = (r_state != S_DONE);

  assign w_accept    = bus.byte_valid && bus.byte_ready;
  assign w_start     = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  assign w_len       = {bus.byte_data, r_count[7:0]};
  assign w_last_word = ((16'(r_idx) + 16'd1) == r_count);

  imem_loader_byte_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_start),
    .i_accept (w_accept && (r_state == S_DATA)),
    .i_byte   (bus.byte_data),
    .o_word   (w_word),
    .o_last   (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_start) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_accept) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (w_accept) begin
          if (w_len == 16'd0)              w_next = S_DONE;
          else if (32'(w_len) > DEPTH)     w_next = S_ERROR;
          else                             w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_last) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_next = w_last_word ? S_DONE : S_DATA;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_idx   <= '0;
      r_addr  <= BASE_ADDR;
      r_wdata <= '0;
    end else begin
      if (w_start) begin
        r_count <= '0;
        r_idx   <= '0;
      end
      if (w_accept && (r_state == S_LEN_LO)) r_count[7:0]  <= bus.byte_data;
      if (w_accept && (r_state == S_LEN_HI)) r_count[15:8] <= bus.byte_data;
      // Address and data are latched on the fourth byte so they are stable throughout WRITE.
      if (w_last) begin
        r_addr  <= BASE_ADDR + (32'(r_idx) << 2);
        r_wdata <= w_word;
      end
      if (r_state == S_WRITE) r_idx <= r_idx + IW'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// Self-checking bench: two loaders (base 0x0 and 0x100) share one stimulus stream.
`default_nettype none

module tb_imem_loader;

  localparam int DEPTH = 256;
  localparam logic [31:0] BASE1 = 32'h0000_0100;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       r_v   = 1'b0;
  logic [7:0] r_d   = 8'h00;

  logic core_reset0, busy0, done0, error0;
  logic core_reset1, busy1, done1, error1;

  imem_loader_if if0 ();
  imem_loader_if if1 ();

  assign if0.byte_valid = r_v;
  assign if0.byte_data  = r_d;
  assign if1.byte_valid = r_v;
  assign if1.byte_data  = r_d;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .bus(if0),
    .core_reset(core_reset0), .busy(busy0), .done(done0), .error(error0)
  );

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .bus(if1),
    .core_reset(core_reset1), .busy(busy1), .done(done1), .error(error1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [31:0] wq[$];
  int acc0 = 0, acc1 = 0;
  int acc_base0 = 0, acc_base1 = 0;

  always @(negedge clk) begin
    if (if0.mem_we) q0.push_back({if0.mem_addr, if0.mem_wdata});
    if (if1.mem_we) q1.push_back({if1.mem_addr, if1.mem_wdata});
  end

  always @(posedge clk) begin
    if (!reset && r_v && if0.byte_ready) acc0++;
    if (!reset && r_v && if1.byte_ready) acc1++;
  end

  typedef struct {
    logic [15:0] count;
    int          max_gap;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    r_v = 1'b0;
    repeat (gap) @(negedge clk);
    r_v = 1'b1;
    r_d = b;
    n = 0;
    while (!if0.byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check("ready_timeout", 64'd0, 64'd1);
      r_v = 1'b0;
      return;
    end
    @(negedge clk);
    r_v = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    q0.delete();
    q1.delete();
    acc_base0 = acc0;
    acc_base1 = acc1;
  endtask

  task automatic fill_words(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom);
  endtask

  task automatic stream_body(input logic [15:0] cnt, input int max_gap);
    send_byte(cnt[7:0], $urandom_range(0, max_gap));
    send_byte(cnt[15:8], $urandom_range(0, max_gap));
    if (cnt != 16'd0 && int'(cnt) <= DEPTH) begin
      for (int i = 0; i < int'(cnt); i++) begin
        for (int k = 0; k < 4; k++) begin
          send_byte(8'((wq[i] >> (8 * k)) & 32'hFF), $urandom_range(0, max_gap));
        end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_stream(input logic [15:0] cnt, input int max_gap);
    pulse_start();
    stream_body(cnt, max_gap);
  endtask

  // Reference: a valid header yields one write per word at base+4*i; otherwise nothing is written.
  task automatic check_load(input string nm, input logic [15:0] cnt, input logic exp_done, input logic exp_err);
    int nexp;
    int nbytes;
    nexp   = (cnt == 16'd0 || int'(cnt) > DEPTH) ? 0 : int'(cnt);
    nbytes = 2 + 4 * nexp;
    check({nm, "_nwr0"}, 64'(q0.size()), 64'(nexp));
    check({nm, "_nwr1"}, 64'(q1.size()), 64'(nexp));
    for (int i = 0; i < nexp && i < q0.size() && i < q1.size(); i++) begin
      check({nm, "_wr0"}, q0[i], {32'(4 * i), wq[i]});
      check({nm, "_wr1"}, q1[i], {BASE1 + 32'(4 * i), wq[i]});
    end
    check({nm, "_done"},  64'({done0, done1}),   64'({exp_done, exp_done}));
    check({nm, "_error"}, 64'({error0, error1}), 64'({exp_err, exp_err}));
    check({nm, "_core_reset"}, 64'({core_reset0, core_reset1}), 64'({!exp_done, !exp_done}));
    check({nm, "_busy"},  64'({busy0, busy1}), 64'd0);
    check({nm, "_ready"}, 64'({if0.byte_ready, if1.byte_ready}), 64'd0);
    check({nm, "_bytes0"}, 64'(acc0 - acc_base0), 64'(nbytes));
    check({nm, "_bytes1"}, 64'(acc1 - acc_base1), 64'(nbytes));
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_ready"}, 64'({if0.byte_ready, if1.byte_ready}), 64'd0);
    check({nm, "_we"},    64'({if0.mem_we, if1.mem_we}), 64'd0);
    check({nm, "_addr0"}, 64'(if0.mem_addr), 64'd0);
    check({nm, "_addr1"}, 64'(if1.mem_addr), 64'(BASE1));
    check({nm, "_wdata"}, {if0.mem_wdata, if1.mem_wdata}, 64'd0);
    check({nm, "_flags0"}, 64'({core_reset0, busy0, done0, error0}), 64'b1000);
    check({nm, "_flags1"}, 64'({core_reset1, busy1, done1, error1}), 64'b1000);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{count: 16'd1,     max_gap: 0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{count: 16'd3,     max_gap: 2, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{count: 16'd256,   max_gap: 0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{count: 16'd257,   max_gap: 1, exp_done: 1'b0, exp_err: 1'b1};
    vecs[4] = '{count: 16'hFFFF,  max_gap: 0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[5] = '{count: 16'd5,     max_gap: 3, exp_done: 1'b1, exp_err: 1'b0};

    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // Two-word load from IDLE with the reference instructions.
    wq.delete();
    wq.push_back(32'h0010_0513);
    wq.push_back(32'h0020_0593);
    run_stream(16'd2, 0);
    check_load("two_word", 16'd2, 1'b1, 1'b0);

    // Zero length: DONE right after the second header byte.
    pulse_start();
    check("zero_core_reset_on_start", 64'({core_reset0, done0}), 64'b10);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("zero_done_immediate", 64'({done0, core_reset0, done1}), 64'b101);
    repeat (2) @(negedge clk);
    check_load("zero", 16'd0, 1'b1, 1'b0);

    // Overflow then recovery.
    run_stream(16'd257, 0);
    check_load("ovf", 16'd257, 1'b0, 1'b1);
    fill_words(2);
    run_stream(16'd2, 1);
    check_load("ovf_recover", 16'd2, 1'b1, 1'b0);

    // Backpressure: three idle cycles before every byte.
    wq.delete();
    wq.push_back(32'hDEAD_BEEF);
    pulse_start();
    send_byte(8'h01, 3);
    send_byte(8'h00, 3);
    send_byte(8'hEF, 3);
    send_byte(8'hBE, 3);
    send_byte(8'hAD, 3);
    send_byte(8'hDE, 3);
    repeat (3) @(negedge clk);
    check_load("bp", 16'd1, 1'b1, 1'b0);
    r_v = 1'b1;
    r_d = 8'h55;
    repeat (4) @(negedge clk);
    r_v = 1'b0;
    check("bp_no_extra_bytes", 64'(acc0 - acc_base0), 64'd6);
    check("bp_still_done", 64'({done0, q0.size() == 1}), 64'b11);

    // Reset after two bytes of word 1 of a three-word load.
    fill_words(3);
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 4; k++) send_byte(8'((wq[0] >> (8 * k)) & 32'hFF), 0);
    send_byte(8'(wq[1] & 32'hFF), 1);
    send_byte(8'((wq[1] >> 8) & 32'hFF), 0);
    #2 reset = 1'b1;
    #1 check_reset_vals("midreset");
    check("midreset_word0_written", 64'(q0.size()), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_stream(16'd3, 1);
    check_load("after_reset", 16'd3, 1'b1, 1'b0);

    // Restart from DONE: core_reset re-asserts on start, write lands at BASE_ADDR.
    fill_words(1);
    pulse_start();
    check("restart_core_reset", 64'({core_reset1, done1, busy1}), 64'b101);
    stream_body(16'd1, 0);
    check_load("restart", 16'd1, 1'b1, 1'b0);

    // Table-driven randomized loads.
    for (int v = 0; v < 6; v++) begin
      fill_words((int'(vecs[v].count) <= DEPTH) ? int'(vecs[v].count) : 0);
      run_stream(vecs[v].count, vecs[v].max_gap);
      check_load($sformatf("vec%0d", v), vecs[v].count, vecs[v].exp_done, vecs[v].exp_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
